// File: rtl/siphash_pkg.sv
// Shared constants, FSM state type and rotate helper for the SipHash controller.
package siphash_pkg;

  // SipHash initialisation vectors ("somepseudorandomlygeneratedbytes").
  localparam logic [63:0] IvV0 = 64'h736f6d6570736575;
  localparam logic [63:0] IvV1 = 64'h646f72616e646f6d;
  localparam logic [63:0] IvV2 = 64'h6c7967656e657261;
  localparam logic [63:0] IvV3 = 64'h7465646279746573;

  // SipRound rotation amounts.
  localparam int unsigned RotV1A = 13;
  localparam int unsigned RotV3A = 16;
  localparam int unsigned RotV3B = 21;
  localparam int unsigned RotV1B = 17;
  localparam int unsigned RotHalf = 32;

  typedef enum logic [2:0] {
    StIdle,
    StAbsorb,
    StComp,
    StPad,
    StFinal,
    StDone
  } state_e;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/siphash_if.sv
// Host-side message stream and tag handshake bundle.
interface siphash_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic [3:0]  s_bytes;
  logic        h_valid;
  logic        h_ready;
  logic [63:0] h_data;

  modport master (
    output s_valid, s_data, s_last, s_bytes, h_ready,
    input  s_ready, h_valid, h_data
  );

  modport slave (
    input  s_valid, s_data, s_last, s_bytes, h_ready,
    output s_ready, h_valid, h_data
  );
endinterface

// File: rtl/sip_round_comb.sv
// One combinational SipRound over the four 64-bit state words.
module sip_round_comb
  import siphash_pkg::*;
(
  input  logic [63:0] i_v0,
  input  logic [63:0] i_v1,
  input  logic [63:0] i_v2,
  input  logic [63:0] i_v3,
  output logic [63:0] o_v0,
  output logic [63:0] o_v1,
  output logic [63:0] o_v2,
  output logic [63:0] o_v3
);

  logic [63:0] w_a0, w_a0r, w_b1, w_c0, w_d1, w_a1, w_d2, w_c1, w_b2, w_c2;

  // Two half-rounds; additions wrap mod 2^64 by width.
  assign w_a0  = i_v0 + i_v1;
  assign w_b1  = rotl64(i_v1, RotV1A) ^ w_a0;
  assign w_a0r = rotl64(w_a0, RotHalf);
  assign w_c0  = i_v2 + i_v3;
  assign w_d1  = rotl64(i_v3, RotV3A) ^ w_c0;
  assign w_a1  = w_a0r + w_d1;
  assign w_d2  = rotl64(w_d1, RotV3B) ^ w_a1;
  assign w_c1  = w_c0 + w_b1;
  assign w_b2  = rotl64(w_b1, RotV1B) ^ w_c1;
  assign w_c2  = rotl64(w_c1, RotHalf);

  assign o_v0 = w_a1;
  assign o_v1 = w_b2;
  assign o_v2 = w_c2;
  assign o_v3 = w_d2;

endmodule

// File: rtl/siphash_ctrl.sv
// Iterative SipHash-c-d controller: absorbs 64-bit words, pads, finalizes, emits tag.
module siphash_ctrl
  import siphash_pkg::*;
#(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  siphash_if.slave     bus,
  output logic         busy
);

  localparam int unsigned MaxRounds = (C_ROUNDS > D_ROUNDS) ? C_ROUNDS : D_ROUNDS;
  localparam int unsigned CntW = $clog2(MaxRounds) + 1;
  localparam logic [CntW-1:0] CLoad = CntW'(C_ROUNDS - 1);
  localparam logic [CntW-1:0] DLoad = CntW'(D_ROUNDS - 1);

  state_e          r_state;
  logic [63:0]     r_v0, r_v1, r_v2, r_v3;
  logic [63:0]     r_m;
  logic [7:0]      r_len;
  logic            r_pad;
  logic            r_last;
  logic [CntW-1:0] r_cnt;
  logic            r_s_ready;
  logic            r_h_valid;
  logic [63:0]     r_h_data;
  logic            r_busy;

  logic [63:0] w_rv0, w_rv1, w_rv2, w_rv3;
  logic        w_accept;
  logic [3:0]  w_bytes;
  logic        w_full;
  logic [7:0]  w_len_next;
  logic [63:0] w_m;
  logic [63:0] w_pad_m;
  logic [63:0] w_k0, w_k1;

  sip_round_comb u_round (
    .i_v0 (r_v0),
    .i_v1 (r_v1),
    .i_v2 (r_v2),
    .i_v3 (r_v3),
    .o_v0 (w_rv0),
    .o_v1 (w_rv1),
    .o_v2 (w_rv2),
    .o_v3 (w_rv3)
  );

  assign w_k0     = key[63:0];
  assign w_k1     = key[127:64];
  assign w_accept = r_s_ready & bus.s_valid;
  // Non-last words always count as 8 bytes; oversize byte counts clamp to 8.
  assign w_bytes  = !bus.s_last ? 4'd8 : ((bus.s_bytes > 4'd8) ? 4'd8 : bus.s_bytes);
  assign w_full   = (w_bytes == 4'd8);
  // A fresh message restarts the count from zero.
  assign w_len_next = ((r_state == StIdle) ? 8'd0 : r_len) + {4'd0, w_bytes};
  assign w_pad_m    = {r_len, 56'd0};

  // Block word: a short last word is masked and carries the length byte on top.
  always_comb begin
    w_m = bus.s_data;
    if (bus.s_last && !w_full) begin
      for (int i = 0; i < 8; i++) begin
        if (i >= int'(w_bytes)) w_m[8*i +: 8] = 8'h00;
      end
      w_m[63:56] = w_len_next;
    end
  end

  // Controller FSM with round datapath state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_v0      <= '0;
      r_v1      <= '0;
      r_v2      <= '0;
      r_v3      <= '0;
      r_m       <= '0;
      r_len     <= '0;
      r_pad     <= 1'b0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_s_ready <= 1'b0;
      r_h_valid <= 1'b0;
      r_h_data  <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_v0      <= w_k0 ^ IvV0;
            r_v1      <= w_k1 ^ IvV1;
            r_v2      <= w_k0 ^ IvV2;
            r_v3      <= w_k1 ^ IvV3 ^ w_m;
            r_m       <= w_m;
            r_len     <= w_len_next;
            r_last    <= bus.s_last & ~w_full;
            r_pad     <= bus.s_last & w_full;
            r_cnt     <= CLoad;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= StComp;
          end else begin
            r_s_ready <= 1'b1;
          end
        end
        StAbsorb: begin
          if (w_accept) begin
            r_v3      <= r_v3 ^ w_m;
            r_m       <= w_m;
            r_len     <= w_len_next;
            r_last    <= bus.s_last & ~w_full;
            r_pad     <= bus.s_last & w_full;
            r_cnt     <= CLoad;
            r_s_ready <= 1'b0;
            r_state   <= StComp;
          end
        end
        StComp: begin
          r_v0 <= w_rv0;
          r_v1 <= w_rv1;
          r_v2 <= w_rv2;
          r_v3 <= w_rv3;
          if (r_cnt == '0) begin
            r_v0 <= w_rv0 ^ r_m;
            if (r_pad) begin
              r_state <= StPad;
            end else if (r_last) begin
              r_v2    <= w_rv2 ^ 64'hff;
              r_cnt   <= DLoad;
              r_state <= StFinal;
            end else begin
              r_s_ready <= 1'b1;
              r_state   <= StAbsorb;
            end
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StPad: begin
          r_v3    <= r_v3 ^ w_pad_m;
          r_m     <= w_pad_m;
          r_pad   <= 1'b0;
          r_last  <= 1'b1;
          r_cnt   <= CLoad;
          r_state <= StComp;
        end
        StFinal: begin
          r_v0 <= w_rv0;
          r_v1 <= w_rv1;
          r_v2 <= w_rv2;
          r_v3 <= w_rv3;
          if (r_cnt == '0) begin
            r_h_data  <= w_rv0 ^ w_rv1 ^ w_rv2 ^ w_rv3;
            r_h_valid <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StDone: begin
          if (bus.h_ready) begin
            r_h_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Gate with rst_n so a reset cycle never advertises readiness.
  assign bus.s_ready = r_s_ready & rst_n;
  assign bus.h_valid = r_h_valid;
  assign bus.h_data  = r_h_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_siphash_ctrl.sv
// Directed bench for siphash_ctrl (SipHash-2-4) with a byte-level reference model.
module tb_siphash_ctrl;

  localparam logic [127:0] KeyRef = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key;
  logic         busy;
  int           n_cmp = 0;
  int           n_bad = 0;

  siphash_if bus ();

  siphash_ctrl #(
    .C_ROUNDS (2),
    .D_ROUNDS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          gap;
    int          stall;
    logic [63:0] tag;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // State packed as {v3, v2, v1, v0}.
  function automatic logic [255:0] ref_round(input logic [255:0] s);
    logic [63:0] a, b, c, d;
    a = s[63:0]; b = s[127:64]; c = s[191:128]; d = s[255:192];
    a = a + b; b = rotl(b, 13) ^ a; a = rotl(a, 32);
    c = c + d; d = rotl(d, 16) ^ c;
    a = a + d; d = rotl(d, 21) ^ a;
    c = c + b; b = rotl(b, 17) ^ c; c = rotl(c, 32);
    return {d, c, b, a};
  endfunction

  // Message byte k is (k mod 256); block j holds bytes 8j..8j+n-1, zero above.
  function automatic logic [63:0] msg_block(input int j, input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[8*i +: 8] = 8'(8 * j + i);
    return m;
  endfunction

  // Same bytes, but unused lanes filled with junk that the DUT must discard.
  function automatic logic [63:0] stim_word(input int j, input int n);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = (i < n) ? 8'(8 * j + i) : 8'ha5;
    return m;
  endfunction

  function automatic logic [63:0] sip_model(input int len);
    logic [63:0]  k0, k1, m;
    logic [255:0] s;
    k0 = KeyRef[63:0];
    k1 = KeyRef[127:64];
    s  = {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
          k1 ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
    for (int j = 0; j <= len / 8; j++) begin
      if (j < len / 8) m = msg_block(j, 8);
      else m = msg_block(j, len % 8) | {8'(len), 56'd0};
      s[255:192] = s[255:192] ^ m;
      s = ref_round(s);
      s = ref_round(s);
      s[63:0] = s[63:0] ^ m;
    end
    s[191:128] = s[191:128] ^ 64'hff;
    for (int r = 0; r < 4; r++) s = ref_round(s);
    return s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
  endfunction

  // Sends one message, measures latency, checks tag, stalls, completes handshake.
  task automatic run_msg(input int len, input int gap, input int stall,
                         input logic [63:0] exp_tag, input int exp_lat);
    int  nwords, lastb, lat, t, bad_ival, bad_busy, bad_rdy;
    time last_t;
    nwords = (len == 0) ? 1 : (len + 7) / 8;
    lastb = len - 8 * (nwords - 1);
    bad_ival = 0; bad_busy = 0; bad_rdy = 0; last_t = 0;
    key = KeyRef;
    for (int w = 0; w < nwords; w++) begin
      bit lst;
      int nb;
      lst = (w == nwords - 1);
      nb = lst ? lastb : 8;
      bus.s_data  = stim_word(w, nb);
      bus.s_last  = lst;
      bus.s_bytes = lst ? 4'(nb) : 4'($urandom_range(0, 15));
      bus.s_valid = 1'b1;
      t = 0;
      while (!bus.s_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        check($sformatf("len%0d s_ready timeout", len), 64'd0, 64'd1);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (w > 0 && ($time - last_t) != 30) bad_ival++;
      last_t = $time;
      @(negedge clk);
      bus.s_valid = 1'b0;
      key = ~KeyRef;
      if (!lst) begin
        if (bus.s_ready) bad_rdy++;
        repeat (gap) @(negedge clk);
      end
    end
    lat = 1;
    while (!bus.h_valid && lat < 40) begin
      if (bus.s_ready || !busy) bad_busy++;
      @(negedge clk);
      lat++;
    end
    check($sformatf("len%0d latency", len), 64'(lat), 64'(exp_lat));
    check($sformatf("len%0d tag", len), bus.h_data, exp_tag);
    check($sformatf("len%0d ready/busy while hashing", len), 64'(bad_busy), 64'd0);
    if (nwords > 1) check($sformatf("len%0d s_ready in COMP", len), 64'(bad_rdy), 64'd0);
    if (gap == 0 && nwords > 1)
      check($sformatf("len%0d word interval", len), 64'(bad_ival), 64'd0);
    for (int i = 0; i < stall; i++) begin
      check($sformatf("len%0d stall%0d h_valid", len, i), 64'(bus.h_valid), 64'd1);
      check($sformatf("len%0d stall%0d h_data", len, i), bus.h_data, exp_tag);
      @(negedge clk);
    end
    bus.h_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.h_ready = 1'b0;
    check($sformatf("len%0d h_valid after handshake", len), 64'(bus.h_valid), 64'd0);
    check($sformatf("len%0d s_ready after handshake", len), 64'(bus.s_ready), 64'd1);
  endtask

  initial begin
    vec_t vecs[9];
    int   spurious;

    vecs[0] = '{0,   0, 0, 64'h726fdb47dd0e0e31, 7};
    vecs[1] = '{1,   0, 0, 64'h74f839c593dc67fd, 7};
    vecs[2] = '{7,   0, 0, 64'hab0200f58b01d137, 7};
    vecs[3] = '{8,   0, 0, 64'h93f5f5799a932462, 10};
    vecs[4] = '{15,  3, 5, 64'ha129ca6149be45e5, 7};
    vecs[5] = '{16,  0, 0, sip_model(16), 10};
    vecs[6] = '{63,  1, 0, sip_model(63), 7};
    vecs[7] = '{256, 0, 0, sip_model(256), 10};
    vecs[8] = '{300, 0, 0, sip_model(300), 7};

    key = KeyRef;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_bytes = '0;
    bus.h_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset s_ready", 64'(bus.s_ready), 64'd0);
    check("reset h_valid", 64'(bus.h_valid), 64'd0);
    check("reset h_data", bus.h_data, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++)
      run_msg(vecs[v].len, vecs[v].gap, vecs[v].stall, vecs[v].tag, vecs[v].lat);

    // Reset pulse while in FINAL aborts the message.
    key = KeyRef;
    bus.s_data  = 64'ha5a5a5a5a5a5a5a5;
    bus.s_last  = 1'b1;
    bus.s_bytes = 4'd0;
    bus.s_valid = 1'b1;
    for (int t = 0; t < 100 && !bus.s_ready; t++) @(negedge clk);
    check("abort s_ready before accept", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort h_valid", 64'(bus.h_valid), 64'd0);
    check("abort h_data", bus.h_data, 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort s_ready", 64'(bus.s_ready), 64'd0);
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.h_valid) spurious++;
    end
    check("abort no h_valid", 64'(spurious), 64'd0);
    run_msg(0, 0, 0, 64'h726fdb47dd0e0e31, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
